alu_share_arb: RTL

- Shares the single combinational ALU between NUM_REQ requesters, e.g. the execute stage, branch-compare logic and the address/PC+4 path.
- Round-robin arbitration with valid/ready handshakes on both sides.
- Two-stage pipeline:
  - Stage A: granted operands are registered and drive the ALU.
  - Stage B: the ALU result is registered and returned with the requester ID.
- Sits between the pipeline front-ends and the ALU instance; all ALU func codes pass through unchanged.

---
 rtl/alu_share_arb_pkg.sv | 35 +++
 rtl/alu_share_arb_if.sv | 37 +++
 rtl/alu_share_arb_rr_arbiter.sv | 42 ++++
 rtl/alu_share_arb.sv | 107 ++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU func codes, datapath
// widths and the operand bundle carried through stage A.
package alu_share_arb_pkg;

  localparam int FUNC_W = 4;
  localparam int DATA_W = 32;

  localparam logic [FUNC_W-1:0] FN_ADD  = 4'b0000;
  localparam logic [FUNC_W-1:0] FN_SUB  = 4'b0001;
  localparam logic [FUNC_W-1:0] FN_XOR  = 4'b0010;
  localparam logic [FUNC_W-1:0] FN_OR   = 4'b0011;
  localparam logic [FUNC_W-1:0] FN_AND  = 4'b0100;
  localparam logic [FUNC_W-1:0] FN_SLTU = 4'b0101;
  localparam logic [FUNC_W-1:0] FN_SLT  = 4'b0110;
  localparam logic [FUNC_W-1:0] FN_SLL  = 4'b0111;
  localparam logic [FUNC_W-1:0] FN_SRL  = 4'b1000;
  localparam logic [FUNC_W-1:0] FN_SRA  = 4'b1001;
  localparam logic [FUNC_W-1:0] FN_SEQ  = 4'b1010;
  localparam logic [FUNC_W-1:0] FN_SNE  = 4'b1011;
  localparam logic [FUNC_W-1:0] FN_SGEU = 4'b1100;
  localparam logic [FUNC_W-1:0] FN_SGE  = 4'b1101;
  localparam logic [FUNC_W-1:0] FN_PC4  = 4'b1110;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } alu_op_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of requester, response and ALU-side signals around the arbiter.
// slave is the arbiter's view; master is the view of everything around it
// (requesters, result consumer and the external ALU).
interface alu_share_arb_if
  import alu_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FUNC_W*NUM_REQ-1:0] req_func;
  logic [DATA_W*NUM_REQ-1:0] req_src1;
  logic [DATA_W*NUM_REQ-1:0] req_src2;

  logic [DATA_W-1:0]         alu_src1;
  logic [DATA_W-1:0]         alu_src2;
  logic [FUNC_W-1:0]         alu_func;
  logic [DATA_W-1:0]         alu_out;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_data;

  modport slave (
    input  req_valid, req_func, req_src1, req_src2, alu_out, resp_ready,
    output req_ready, alu_src1, alu_src2, alu_func, resp_valid, resp_id, resp_data
  );

  modport master (
    output req_valid, req_func, req_src1, req_src2, alu_out, resp_ready,
    input  req_ready, alu_src1, alu_src2, alu_func, resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr (mod NUM_REQ)
// and grants the first asserted request. ptr must be below NUM_REQ.
module alu_share_arb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Pad the request vector to a power of two so an ID_W-bit index is always in range.
  localparam int SLOTS = 1 << ID_W;

  logic [SLOTS-1:0] req_ext;
  logic [ID_W:0]    cand;
  logic [ID_W-1:0]  slot;

  // Rotating priority scan, then one-hot decode of the winning index.
  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    slot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      slot = cand[ID_W-1:0];
      if (!any && req_ext[slot]) begin
        any = 1'b1;
        idx = slot;
      end
    end
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) gnt[i] = any && (idx == ID_W'(i));
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// Stage A holds the granted operands and drives the ALU; stage B captures
// the ALU result together with the owning requester index.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic           clk,
  input  logic           reset,
  alu_share_arb_if.slave bus
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic               win_any;
  alu_op_t            win_op;

  logic               adv_a;
  logic               adv_b;
  logic               req_hs;

  logic               a_valid;
  alu_op_t            a_op;
  logic [ID_W-1:0]    a_id;

  logic               b_valid;
  logic [DATA_W-1:0]  b_data;
  logic [ID_W-1:0]    b_id;

  alu_share_arb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Each stage moves when it is empty or the stage downstream moves.
  assign adv_b  = !b_valid || bus.resp_ready;
  assign adv_a  = !a_valid || adv_b;

  // reset gates ready so nothing is offered while the flops are held in reset.
  assign req_hs        = win_any && adv_a && reset;
  assign bus.req_ready = win_gnt & {NUM_REQ{adv_a && reset}};

  // Select the winner's operand bundle from the packed request buses.
  always_comb begin
    win_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) begin
        win_op.func = bus.req_func[FUNC_W*i +: FUNC_W];
        win_op.src1 = bus.req_src1[DATA_W*i +: DATA_W];
        win_op.src2 = bus.req_src2[DATA_W*i +: DATA_W];
      end
    end
  end

  // Round-robin pointer moves past the winner only on an accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else if (req_hs) rr_ptr <= ID_W'(rr_next(int'(win_idx), NUM_REQ));
  end

  // Stage A: operand registers keep their last value when empty so the ALU inputs stay quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid <= 1'b0;
      a_op    <= '0;
      a_id    <= '0;
    end else if (adv_a) begin
      a_valid <= win_any;
      if (win_any) begin
        a_op <= win_op;
        a_id <= win_idx;
      end
    end
  end

  // Stage B: capture the ALU result and owner; held stable while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_valid <= 1'b0;
      b_data  <= '0;
      b_id    <= '0;
    end else if (adv_b) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_data <= bus.alu_out;
        b_id   <= a_id;
      end
    end
  end

  assign bus.alu_src1   = a_op.src1;
  assign bus.alu_src2   = a_op.src2;
  assign bus.alu_func   = a_op.func;
  assign bus.resp_valid = b_valid;
  assign bus.resp_id    = b_id;
  assign bus.resp_data  = b_data;

endmodule
